// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Shares the variable-length write port of a byte shift-register FIFO among
// NUM_REQ producers. Arbitration is round-robin. A requester that sends a word
// with last=0 locks the grant until it sends its last word. A write is only
// issued when the FIFO is known to have room for it, so the FIFO never drops
// a write.
//
// Optional feature: define ARB_BYTE_CNT_EN to add the byte_total port, a
// wrapping 16-bit count of all bytes written.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester valid
//   req_last     per-requester "last word of packet"
//   req_len      per-requester byte count, slice i = [3i+2:3i]
//   req_data     per-requester payload, byte 0 in the LSBs of each slice
//   req_ready    one-hot accept (combinational)
//   fifo_count   FIFO data_count
//   wr_en        FIFO write strobe (registered)
//   wr_data      FIFO write data (registered)
//   wr_len       FIFO write length (registered)
//   grant_id     index of the last accepted requester
//   locked       high while a packet holds the grant
//   len_err      one-cycle pulse after an illegal length is consumed
//   byte_total   bytes written (ARB_BYTE_CNT_EN only)
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_WR_BYTES = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0]                         req_last,
  input  logic [3*NUM_REQ-1:0]                       req_len,
  input  logic [NUM_REQ*DATA_WIDTH*MAX_WR_BYTES-1:0] req_data,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [$clog2(FIFO_DEPTH):0]                fifo_count,
  output logic                                       wr_en,
  output logic [DATA_WIDTH*MAX_WR_BYTES-1:0]         wr_data,
  output logic [2:0]                                 wr_len,
  output logic [$clog2(NUM_REQ)-1:0]                 grant_id,
  output logic                                       locked,
  output logic                                       len_err
`ifdef ARB_BYTE_CNT_EN
  ,
  output logic [15:0]                                byte_total
`endif
);

  localparam int WW = DATA_WIDTH * MAX_WR_BYTES;
  localparam int IW = $clog2(NUM_REQ);
  // Wide enough that FIFO_DEPTH - max fifo_count - max wr_len stays in range.
  localparam int SW = $clog2(FIFO_DEPTH) + 3;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_lock_id;
  logic            r_wr_en;
  logic [WW-1:0]   r_wr_data;
  logic [2:0]      r_wr_len;
  logic [IW-1:0]   r_grant_id;
  logic            r_locked;
  logic            r_len_err;

  logic [2:0]      w_len_arr  [NUM_REQ];
  logic [WW-1:0]   w_data_arr [NUM_REQ];
  logic [SW-1:0]   w_space_raw;
  logic [SW-1:0]   w_space;
  logic [IW-1:0]   w_cand;
  logic            w_found;
  logic [2:0]      w_len;
  logic            w_len_ok;
  logic            w_fits;
  logic            w_go;
  logic [IW-1:0]   w_rr_next;

  // Unpack the flat request buses and build the one-hot ready.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_len_arr[gi]  = req_len[3*gi +: 3];
    assign w_data_arr[gi] = req_data[gi*WW +: WW];
    assign req_ready[gi]  = w_go && (w_cand == IW'(gi));
  end

  // Free space, conservatively charging the write still in flight and
  // ignoring any concurrent reads. A negative result (including fifo_count
  // above FIFO_DEPTH) wraps to MSB=1 and clamps to zero.
  assign w_space_raw = SW'(FIFO_DEPTH) - SW'(fifo_count)
                     - (r_wr_en ? SW'(r_wr_len) : SW'(0));
  assign w_space     = w_space_raw[SW-1] ? '0 : w_space_raw;

  // Candidate: the locked requester, or the first valid one starting at rr_ptr.
  // The scan runs backwards so the last hit is the highest-priority one.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_cand  = '0;
    if (r_state == ST_LOCK) begin
      w_cand  = r_lock_id;
      w_found = req_valid[r_lock_id];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[idx]) begin
          w_found = 1'b1;
          w_cand  = IW'(idx);
        end
      end
    end
  end

  assign w_len    = w_len_arr[w_cand];
  assign w_len_ok = (w_len != 3'd0) && (int'(w_len) <= MAX_WR_BYTES);
  assign w_fits   = SW'(w_len) <= w_space;
  // Illegal lengths are consumed immediately; legal ones wait for room and
  // block everyone behind them so long writes cannot starve.
  assign w_go     = w_found && (!w_len_ok || w_fits);
  assign w_rr_next = (w_cand == IW'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_wr_len   <= '0;
      r_grant_id <= '0;
      r_locked   <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_wr_en   <= w_go && w_len_ok;
      r_len_err <= w_go && !w_len_ok;
      if (w_go && w_len_ok) begin
        r_wr_data <= w_data_arr[w_cand];
        r_wr_len  <= w_len;
      end
      if (w_go) begin
        r_grant_id <= w_cand;
        if (req_last[w_cand]) begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
          r_rr_ptr <= w_rr_next;
        end else begin
          r_state   <= ST_LOCK;
          r_locked  <= 1'b1;
          r_lock_id <= w_cand;
        end
      end
    end
  end

`ifdef ARB_BYTE_CNT_EN
  logic [15:0] r_byte_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_total <= '0;
    end else if (r_wr_en) begin
      r_byte_total <= r_byte_total + 16'(r_wr_len);
    end
  end

  assign byte_total = r_byte_total;
`endif

  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign wr_len   = r_wr_len;
  assign grant_id = r_grant_id;
  assign locked   = r_locked;
  assign len_err  = r_len_err;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Table of per-cycle vectors (inputs plus expected ready / len_err / locked /
// grant_id) applied in order from reset, with expected FIFO writes queued in
// a scoreboard when a grant is expected and compared one cycle later. A
// hand-written sequence covers asynchronous reset in the middle of a lock.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int MB = 5;
  localparam int FD = 8;
  localparam int WW = DW * MB;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [3*NR-1:0]   req_len;
  logic [NR*WW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [3:0]        fifo_count;
  logic              wr_en;
  logic [WW-1:0]     wr_data;
  logic [2:0]        wr_len;
  logic [1:0]        grant_id;
  logic              locked;
  logic              len_err;
`ifdef ARB_BYTE_CNT_EN
  logic [15:0]       byte_total;
  int                exp_bytes = 0;
`endif

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_WR_BYTES(MB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_len(req_len),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_count(fifo_count),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_len(wr_len),
    .grant_id(grant_id),
    .locked(locked),
    .len_err(len_err)
`ifdef ARB_BYTE_CNT_EN
    ,
    .byte_total(byte_total)
`endif
  );

  typedef struct {
    logic [2:0] valid;
    logic [2:0] last;
    logic [2:0] len0;
    logic [2:0] len1;
    logic [2:0] len2;
    logic [3:0] fc;
    logic [2:0] exp_ready;
    logic       exp_err;
    logic       exp_locked;
    logic [1:0] exp_gid;
  } vec_t;

  typedef struct {
    logic [WW-1:0] data;
    logic [2:0]    len;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [2:0] valid, logic [2:0] last,
                              logic [2:0] len0, logic [2:0] len1, logic [2:0] len2,
                              logic [3:0] fc, logic [2:0] rdy, logic err,
                              logic lck, logic [1:0] gid);
    vec_t v;
    v.valid = valid; v.last = last;
    v.len0 = len0; v.len1 = len1; v.len2 = len2;
    v.fc = fc; v.exp_ready = rdy; v.exp_err = err;
    v.exp_locked = lck; v.exp_gid = gid;
    return v;
  endfunction

  // Distinct payload per requester and vector; requester 0 at n=0 is 0x0504030201.
  function automatic logic [WW-1:0] dat(int i, int n);
    return 40'h0504030201 ^ {8'(i), 24'(n), 8'h00};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_write(input string tag, input bit pushed);
    wr_t e;
    if (pushed) begin
      e = sb.pop_front();
      chk({tag, " wr_en"}, 64'(wr_en), 64'd1);
      chk({tag, " wr_data"}, 64'(wr_data), 64'(e.data));
      chk({tag, " wr_len"}, 64'(wr_len), 64'(e.len));
`ifdef ARB_BYTE_CNT_EN
      exp_bytes += int'(e.len);
`endif
    end else begin
      chk({tag, " wr_en"}, 64'(wr_en), 64'd0);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    string      tag;
    bit         pushed;
    logic [2:0] lens [3];
    tag     = $sformatf("v%0d", n);
    lens[0] = v.len0; lens[1] = v.len1; lens[2] = v.len2;
    req_valid  = v.valid;
    req_last   = v.last;
    req_len    = {v.len2, v.len1, v.len0};
    fifo_count = v.fc;
    for (int i = 0; i < NR; i++) req_data[i*WW +: WW] = dat(i, n);
    #1;
    chk({tag, " ready"}, 64'(req_ready), 64'(v.exp_ready));
    pushed = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (v.exp_ready[i] && !v.exp_err) begin
        sb.push_back('{data: dat(i, n), len: lens[i]});
        pushed = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_write(tag, pushed);
    chk({tag, " len_err"}, 64'(len_err), 64'(v.exp_err));
    chk({tag, " locked"}, 64'(locked), 64'(v.exp_locked));
    chk({tag, " grant_id"}, 64'(grant_id), 64'(v.exp_gid));
    $display("vec %0d: valid=%b ready=%b wr_en=%b wr_len=%0d gid=%0d locked=%b err=%b",
             n, v.valid, req_ready, wr_en, wr_len, grant_id, locked, len_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, " wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, " wr_len"}, 64'(wr_len), 64'd0);
    chk({tag, " grant_id"}, 64'(grant_id), 64'd0);
    chk({tag, " locked"}, 64'(locked), 64'd0);
    chk({tag, " len_err"}, 64'(len_err), 64'd0);
`ifdef ARB_BYTE_CNT_EN
    chk({tag, " byte_total"}, 64'(byte_total), 64'd0);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_len    = '0;
    req_data   = '0;
    fifo_count = '0;

    // Round-robin fill of an empty, never-read FIFO (fifo_count tracks writes).
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 0, 3'b010, 0, 0, 1));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 1, 3'b100, 0, 0, 2));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 2, 3'b001, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 3, 3'b010, 0, 0, 1));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 4, 3'b100, 0, 0, 2));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 5, 3'b001, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 6, 3'b010, 0, 0, 1));
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 7, 3'b000, 0, 0, 1));   // full incl. in-flight
    tbl.push_back(mk(3'b111, 3'b111, 1, 1, 1, 8, 3'b000, 0, 0, 1));   // full
    tbl.push_back(mk(3'b100, 3'b111, 1, 1, 1, 0, 3'b100, 0, 0, 2));   // rr_ptr back to 0
    // Basic 4-byte write from req0.
    tbl.push_back(mk(3'b001, 3'b111, 4, 1, 1, 0, 3'b001, 0, 0, 0));
    // Space check.
    tbl.push_back(mk(3'b000, 3'b111, 4, 4, 1, 0, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 1, 4, 1, 5, 3'b000, 0, 0, 0));   // space 3
    tbl.push_back(mk(3'b010, 3'b111, 1, 4, 1, 4, 3'b010, 0, 0, 1));   // space 4
    tbl.push_back(mk(3'b100, 3'b111, 1, 4, 3, 0, 3'b100, 0, 0, 2));   // wr_len=3 next
    tbl.push_back(mk(3'b010, 3'b111, 1, 4, 3, 2, 3'b000, 0, 0, 2));   // 8-2-3=3 < 4
    tbl.push_back(mk(3'b010, 3'b111, 1, 4, 3, 2, 3'b010, 0, 0, 1));
    // No bypass: req0 len5 blocks req1 len1.
    tbl.push_back(mk(3'b011, 3'b111, 5, 1, 1, 6, 3'b000, 0, 0, 1));   // negative -> 0
    tbl.push_back(mk(3'b011, 3'b111, 5, 1, 1, 6, 3'b000, 0, 0, 1));   // space 2
    tbl.push_back(mk(3'b011, 3'b111, 5, 1, 1, 3, 3'b001, 0, 0, 0));   // space 5
    tbl.push_back(mk(3'b010, 3'b111, 5, 1, 1, 0, 3'b010, 0, 0, 1));
    tbl.push_back(mk(3'b000, 3'b111, 5, 1, 1, 0, 3'b000, 0, 0, 1));
    // Lock: req2 three words, req0 continuously valid, one hold cycle.
    tbl.push_back(mk(3'b101, 3'b001, 1, 1, 1, 0, 3'b100, 0, 1, 2));
    tbl.push_back(mk(3'b101, 3'b001, 1, 1, 1, 0, 3'b100, 0, 1, 2));
    tbl.push_back(mk(3'b001, 3'b001, 1, 1, 1, 0, 3'b000, 0, 1, 2));
    tbl.push_back(mk(3'b101, 3'b101, 1, 1, 1, 0, 3'b100, 0, 0, 2));
    tbl.push_back(mk(3'b001, 3'b001, 1, 1, 1, 0, 3'b001, 0, 0, 0));
    // Illegal lengths (len 0, and len 6 with the FIFO full), then overfull count.
    tbl.push_back(mk(3'b001, 3'b001, 0, 1, 1, 0, 3'b001, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, 6, 1, 8, 3'b010, 1, 0, 1));
    tbl.push_back(mk(3'b000, 3'b000, 1, 1, 1, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(3'b100, 3'b100, 1, 1, 1, 12, 3'b000, 0, 0, 1));
    tbl.push_back(mk(3'b100, 3'b100, 1, 1, 1, 0, 3'b100, 0, 0, 2));

    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    // Asynchronous reset in the middle of a lock.
    req_valid  = 3'b010;
    req_last   = 3'b000;
    req_len    = {3'd1, 3'd2, 3'd1};
    fifo_count = 4'd0;
    for (int i = 0; i < NR; i++) req_data[i*WW +: WW] = dat(i, 100);
    #1;
    chk("mlk ready", 64'(req_ready), 64'b010);
    sb.push_back('{data: dat(1, 100), len: 3'd2});
    @(posedge clk); #1;
    check_write("mlk", 1'b1);
    chk("mlk locked", 64'(locked), 64'd1);
    chk("mlk grant_id", 64'(grant_id), 64'd1);
    $display("mid-lock: locked=%b gid=%0d", locked, grant_id);
    #2 rst_n = 1'b0;
`ifdef ARB_BYTE_CNT_EN
    exp_bytes = 0;
`endif
    #1;
    chk_zero("midrst");
    $display("mid-lock reset: wr_en=%b locked=%b gid=%0d", wr_en, locked, grant_id);
    #1 rst_n = 1'b1;
    req_valid = 3'b011;
    req_last  = 3'b011;
    req_len   = {3'd1, 3'd1, 3'd1};
    #1;
    chk("post ready", 64'(req_ready), 64'b001);
    sb.push_back('{data: dat(0, 100), len: 3'd1});
    @(posedge clk); #1;
    check_write("post", 1'b1);
    chk("post grant_id", 64'(grant_id), 64'd0);
    chk("post locked", 64'(locked), 64'd0);
    $display("post reset: gid=%0d wr_en=%b", grant_id, wr_en);
    req_valid = 3'b000;
    @(posedge clk); #1;
`ifdef ARB_BYTE_CNT_EN
    chk("byte_total", 64'(byte_total), 64'(exp_bytes));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
